pixie_dp_back_end: RTL and testbench

PIXIE_DP_BACK_END -- requirements
Module: pixie_dp_back_end

---
 rtl/pixie_dp_back_end.sv | 122 ++++++++++++
 tb/tb_pixie_dp_back_end.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/pixie_dp_back_end.sv
// Pixie-style video back end: raster timing, frame-buffer byte fetch and a
// 1-bpp shift-out. Every video output advances only on the pixel-rate enable.
module pixie_dp_back_end #(
  parameter int H_TOTAL     = 112,
  parameter int H_ACT_START = 32,
  parameter int H_ACT_BYTES = 8,
  parameter int HSYNC_START = 0,
  parameter int HSYNC_LEN   = 8,
  parameter int V_TOTAL     = 262,
  parameter int V_ACT_START = 80,
  parameter int V_ACT_LINES = 128,
  parameter int VSYNC_START = 0,
  parameter int VSYNC_LEN   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_enable,
  input  logic       display_en,
  input  logic [7:0] mem_data,
  output logic [9:0] mem_rd_addr,
  output logic       mem_rd_en,
  output logic       pixel,
  output logic       hsync,
  output logic       vsync,
  output logic       hblank,
  output logic       vblank,
  output logic       frame_start
);

  localparam int STAGES    = 1;
  localparam int H_ACT_PIX = 8 * H_ACT_BYTES;

  typedef struct packed {
    logic hsync;
    logic vsync;
    logic hblank;
    logic vblank;
  } vid_t;

  logic [6:0]      hcount;
  logic [8:0]      vcount;
  logic            line_on;
  logic [7:0]      shreg;
  logic [7:0]      hold;
  // [0] is the one-clk read strobe, [1] marks the clk mem_data is valid
  logic [STAGES:0] vld_pipe;

  logic [6:0] h_pix;
  logic [6:0] h_fetch;
  logic [8:0] v_line;
  logic       h_wrap;
  logic       v_wrap;
  logic       h_act;
  logic       v_act;
  logic       pix_on;
  logic       load;
  logic       fetch;
  logic [9:0] fetch_addr;
  vid_t       vid;

  // Offsets are computed modulo the counter width so one unsigned compare
  // covers both window edges.
  always_comb begin
    h_wrap     = (hcount == 7'(H_TOTAL - 1));
    v_wrap     = (vcount == 9'(V_TOTAL - 1));
    h_pix      = hcount - 7'(H_ACT_START);
    h_fetch    = hcount - 7'(H_ACT_START - 2);
    v_line     = vcount - 9'(V_ACT_START);
    h_act      = (h_pix < 7'(H_ACT_PIX));
    v_act      = (v_line < 9'(V_ACT_LINES));
    pix_on     = h_act && v_act && line_on;
    load       = pix_on && (h_pix[2:0] == 3'd0);
    fetch      = v_act && line_on && (h_fetch < 7'(H_ACT_PIX)) && (h_fetch[2:0] == 3'd0);
    fetch_addr = 10'(v_line) * 10'(H_ACT_BYTES) + 10'(h_fetch[6:3]);
    vid.hsync  = ((hcount - 7'(HSYNC_START)) < 7'(HSYNC_LEN));
    vid.vsync  = ((vcount - 9'(VSYNC_START)) < 9'(VSYNC_LEN));
    vid.hblank = !h_act;
    vid.vblank = !v_act;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hcount      <= '0;
      vcount      <= '0;
      line_on     <= 1'b0;
      shreg       <= '0;
      hold        <= '0;
      vld_pipe    <= '0;
      mem_rd_addr <= '0;
      pixel       <= 1'b0;
      hsync       <= 1'b0;
      vsync       <= 1'b0;
      hblank      <= 1'b1;
      vblank      <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      // Capture runs off the strobe pipe, independent of the pixel enable.
      vld_pipe    <= {vld_pipe[STAGES-1:0], clk_enable && fetch};
      frame_start <= clk_enable && h_wrap && v_wrap;
      if (vld_pipe[STAGES]) hold <= mem_data;
      if (clk_enable) begin
        hcount <= h_wrap ? '0 : hcount + 7'd1;
        if (h_wrap) vcount <= v_wrap ? '0 : vcount + 9'd1;
        if (hcount == '0) line_on <= display_en;
        {hsync, vsync, hblank, vblank} <= vid;
        if (fetch) mem_rd_addr <= fetch_addr;
        if (load) begin
          pixel <= hold[7];
          shreg <= {hold[6:0], 1'b0};
        end else if (pix_on) begin
          pixel <= shreg[7];
          shreg <= {shreg[6:0], 1'b0};
        end else begin
          pixel <= 1'b0;
        end
      end
    end
  end

  assign mem_rd_en = vld_pipe[0];

endmodule

// File: tb/tb_pixie_dp_back_end.sv
// Directed bench for pixie_dp_back_end: frame timing, fetch addresses, pixel
// bytes under several enable spacings, display_en gating and mid-fetch reset.
module tb_pixie_dp_back_end;

  localparam int HT = 112;
  localparam int VT = 262;

  logic       clk = 1'b0;
  logic       reset;
  logic       clk_enable = 1'b0;
  logic       display_en = 1'b1;
  logic [7:0] mem_data = 8'h00;
  logic [9:0] mem_rd_addr;
  logic       mem_rd_en;
  logic       pixel;
  logic       hsync;
  logic       vsync;
  logic       hblank;
  logic       vblank;
  logic       frame_start;

  pixie_dp_back_end dut (
    .clk         (clk),
    .reset       (reset),
    .clk_enable  (clk_enable),
    .display_en  (display_en),
    .mem_data    (mem_data),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_en   (mem_rd_en),
    .pixel       (pixel),
    .hsync       (hsync),
    .vsync       (vsync),
    .hblank      (hblank),
    .vblank      (vblank),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  logic [7:0] ram [0:1023];
  always @(posedge clk) if (mem_rd_en) mem_data <= ram[mem_rd_addr];

  int n_chk = 0;
  int n_bad = 0;
  int mode  = 0;
  int gap   = 2;
  int cnt   = 0;
  int th = 0, tv = 0, lh = 0, lv = 0, n_en = 0;
  int fs_n = 0, fs_at = 0;
  int rd_tot = 0, rd_bad = 0, rd_wide = 0, rd_in_rst = 0, blank_ones = 0;
  logic rd_prev = 1'b0;

  logic [63:0] line_pix [0:VT-1];
  int          rd_n     [0:VT-1];
  logic [9:0]  rd_a0    [0:VT-1];
  logic [9:0]  rd_a7    [0:VT-1];
  logic        e31      [0:VT-1];
  logic        e96      [0:VT-1];
  logic        vs_l     [0:VT-1];
  logic        vb_l     [0:VT-1];
  logic        hs_a     [0:HT-1];
  logic        hb_a     [0:HT-1];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // One clk: pick the enable for the coming edge, then sample 1 time unit after it.
  task automatic step();
    logic en;
    cnt++;
    if (cnt >= gap) begin
      clk_enable = 1'b1;
      cnt = 0;
      gap = (mode == 2) ? int'($urandom_range(4, 2)) : (mode == 1) ? 3 : 2;
    end else begin
      clk_enable = 1'b0;
    end
    @(posedge clk);
    en = clk_enable;
    #1;
    if (reset) begin
      th = 0; tv = 0; n_en = 0; fs_n = 0; rd_tot = 0; rd_prev = 1'b0;
      if (mem_rd_en) rd_in_rst++;
    end else begin
      if (en) begin
        lh = th; lv = tv; n_en++;
        if (th == HT - 1) begin
          th = 0;
          tv = (tv == VT - 1) ? 0 : tv + 1;
        end else begin
          th++;
        end
        if (lh == 0) begin
          line_pix[lv] = '0; rd_n[lv] = 0; vs_l[lv] = vsync; vb_l[lv] = vblank;
        end
        hs_a[lh] = hsync;
        hb_a[lh] = hblank;
        if (lh >= 32 && lh < 96 && lv >= 80 && lv < 208) line_pix[lv][95-lh] = pixel;
        else if (pixel) blank_ones++;
        if (lh == 31) e31[lv] = pixel;
        if (lh == 96) e96[lv] = pixel;
      end
      if (frame_start) begin
        fs_n++;
        fs_at = n_en;
      end
      if (mem_rd_en) begin
        rd_tot++;
        rd_n[lv]++;
        if (rd_prev || !en) rd_wide++;
        if (lv < 80 || lv >= 208 || lh < 30 || lh >= 94 || ((lh - 30) % 8) != 0 ||
            mem_rd_addr != 10'((lv - 80) * 8 + (lh - 30) / 8)) rd_bad++;
        if (lh == 30) rd_a0[lv] = mem_rd_addr;
        if (lh == 86) rd_a7[lv] = mem_rd_addr;
      end
      rd_prev = mem_rd_en;
    end
  endtask

  task automatic run_to(input int h, input int v, input string tag);
    int budget;
    budget = 70000;
    while (!(th == h && tv == v) && budget > 0) begin
      step();
      budget--;
    end
    chk(tag, {th, tv}, {h, v});
  endtask

  initial begin
    int budget;
    reset = 1'b1;
    for (int i = 0; i < 1024; i++) ram[i] = i[7:0];
    ram[0] = 8'hA5;

    repeat (3) step();
    chk("rst_vid", {pixel, hsync, vsync, hblank, vblank, frame_start, mem_rd_en}, 7'b0001100);
    chk("rst_addr", mem_rd_addr, 10'd0);
    reset = 1'b0;

    // Enable every 2nd clk through line 80, every 3rd on 81, random on 82.
    mode = 0;
    run_to(0, 81, "to_l81");
    chk("l80_pix", line_pix[80], 64'hA501020304050607);
    chk("l80_edge", {e31[80], e96[80]}, 2'b00);
    chk("l80_rdn", rd_n[80], 8);
    chk("l80_addr", {rd_a0[80], rd_a7[80]}, {10'd0, 10'd7});
    chk("l79_rdn", rd_n[79], 0);
    mode = 1;
    run_to(0, 82, "to_l82");
    chk("l81_pix_div3", line_pix[81], 64'h08090A0B0C0D0E0F);
    mode = 2;
    run_to(0, 83, "to_l83");
    chk("l82_pix_rand", line_pix[82], 64'h1011121314151617);
    mode = 0;

    // Reset lands right after the fetch issued at hcount 46 of line 90.
    run_to(47, 90, "to_l90_h46");
    chk("fetch_46", {mem_rd_en, mem_rd_addr}, {1'b1, 10'd82});
    reset = 1'b1;
    #1;
    chk("rst_mid_vid", {pixel, hsync, vsync, hblank, vblank, frame_start, mem_rd_en}, 7'b0001100);
    chk("rst_mid_addr", mem_rd_addr, 10'd0);
    repeat (4) step();
    reset = 1'b0;

    budget = 62000;
    while (fs_n == 0 && budget > 0) begin
      if (th == 50 && tv == 100) display_en = 1'b0;
      if (th == 0 && tv == 102) display_en = 1'b1;
      step();
      budget--;
    end
    chk("fs_at", fs_at, 29344);
    chk("l100_pix", line_pix[100], 64'hA0A1A2A3A4A5A6A7);
    chk("l101_pix", line_pix[101], 64'h0);
    chk("l101_rdn", rd_n[101], 0);
    chk("l102_pix", line_pix[102], 64'hB0B1B2B3B4B5B6B7);
    chk("l102_rdn", rd_n[102], 8);
    chk("l207_pix", line_pix[207], 64'hF8F9FAFBFCFDFEFF);
    chk("l207_rdn", rd_n[207], 8);
    chk("l207_addr", {rd_a0[207], rd_a7[207]}, {10'd1016, 10'd1023});
    chk("l208_rdn", rd_n[208], 0);
    chk("vsync", {vs_l[0], vs_l[3], vs_l[4], vs_l[261]}, 4'b1100);
    chk("vblank", {vb_l[79], vb_l[80], vb_l[207], vb_l[208]}, 4'b1001);
    chk("hsync", {hs_a[0], hs_a[7], hs_a[8], hs_a[111]}, 4'b1100);
    chk("hblank", {hb_a[31], hb_a[32], hb_a[95], hb_a[96]}, 4'b1001);
    chk("rd_tot", rd_tot, 1016);
    step();
    chk("fs_pulse", frame_start, 1'b0);
    chk("fs_n", fs_n, 1);
    chk("blank_pix", blank_ones, 0);
    chk("rd_bad", rd_bad, 0);
    chk("rd_wide", rd_wide, 0);
    chk("rd_in_rst", rd_in_rst, 0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
